// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute controller with a timed data-memory handshake
module control_sequencer #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       CLB,
  input  logic [7:0] instr,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       IncPC,
  output logic       LoadPC,
  output logic       selPC,
  output logic [3:0] imm,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic [2:0] alu_op,
  output logic       reg_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       mem_err,
  output logic       illegal,
  output logic [7:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state, state_nx;
  logic [7:0] ir;
  logic [7:0] wait_cnt;
  logic [3:0] op;
  logic       timeout;

  assign op      = ir[7:4];
  assign imm     = ir[3:0];
  assign rs      = ir[1:0];
  // LDI always targets R0 regardless of the encoded rd bits
  assign rd      = (op == 4'h1) ? 2'b00 : ir[3:2];
  assign halted  = (state == S_HALT);
  assign timeout = (state == S_MEM) && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) begin
      state       <= S_FETCH;
      ir          <= 8'h00;
      wait_cnt    <= 8'h00;
      instr_count <= 8'h00;
      mem_err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH)
        ir <= instr;
      if (state == S_MEM)
        wait_cnt <= wait_cnt + 8'h01;
      else
        wait_cnt <= 8'h00;
      if (IncPC || LoadPC)
        instr_count <= instr_count + 8'h01;
      if (timeout)
        mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    IncPC    = 1'b0;
    LoadPC   = 1'b0;
    selPC    = 1'b0;
    alu_op   = 3'd0;
    reg_we   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_FETCH;
        case (op)
          4'h0: IncPC = 1'b1;
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
            reg_we = 1'b1;
            IncPC  = 1'b1;
            alu_op = op[2:0] - 3'd1;
          end
          4'h7, 4'h8: state_nx = S_MEM;
          4'h9: LoadPC = 1'b1;
          4'hA: begin
            LoadPC = 1'b1;
            selPC  = 1'b1;
          end
          4'hB: begin
            if (zero_flag)
              LoadPC = 1'b1;
            else
              IncPC = 1'b1;
          end
          4'hF: state_nx = S_HALT;
          default: begin
            IncPC   = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == 4'h8);
        if (mem_ready) begin
          reg_we   = (op == 4'h7);
          IncPC    = 1'b1;
          state_nx = S_FETCH;
        end else if (timeout) begin
          state_nx = S_HALT;
        end
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;
  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       CLB;
  logic [7:0] instr;
  logic       zero_flag;
  logic       mem_ready;
  logic       IncPC, LoadPC, selPC, reg_we, mem_req, mem_we, halted, mem_err, illegal;
  logic [3:0] imm;
  logic [1:0] rd, rs;
  logic [2:0] alu_op;
  logic [7:0] instr_count;

  control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .CLB(CLB), .instr(instr), .zero_flag(zero_flag), .mem_ready(mem_ready),
    .IncPC(IncPC), .LoadPC(LoadPC), .selPC(selPC), .imm(imm), .rd(rd), .rs(rs),
    .alu_op(alu_op), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
    .halted(halted), .mem_err(mem_err), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [27:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  m_ir;
  logic [7:0]  m_cnt;
  logic        m_merr;

  wire [27:0] obs_vec = {IncPC, LoadPC, selPC, imm, rd, rs, alu_op, reg_we, mem_req,
                         mem_we, halted, mem_err, illegal, instr_count};

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h (inc,load,sel,imm,rd,rs,alu,we,req,mwe,halt,err,ill,cnt)",
               tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [27:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, obs_vec, e);
    end
  end

  function automatic logic [27:0] ev(input logic inc, input logic load, input logic sel,
                                     input logic [2:0] alu, input logic we, input logic req,
                                     input logic mwe, input logic hlt, input logic ill);
    logic [1:0] rdv;
    rdv = (m_ir[7:4] == 4'h1) ? 2'b00 : m_ir[3:2];
    return {inc, load, sel, m_ir[3:0], rdv, m_ir[1:0], alu, we, req, mwe, hlt, m_merr, ill, m_cnt};
  endfunction

  task automatic step(input logic [27:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    if (e[27] | e[26]) m_cnt = m_cnt + 8'h01;
  endtask

  task automatic model_reset();
    m_ir   = 8'h00;
    m_cnt  = 8'h00;
    m_merr = 1'b0;
  endtask

  task automatic do_reset();
    CLB = 1'b1;
    instr = 8'hFF;
    mem_ready = 1'b1;
    model_reset();
    step(ev(0, 0, 0, 3'd0, 0, 0, 0, 0, 0), "reset");
    step(ev(0, 0, 0, 3'd0, 0, 0, 0, 0, 0), "reset_hold");
    CLB = 1'b0;
  endtask

  task automatic run(input logic [7:0] ins, input logic z, input int rdy_at, input int abort_at);
    logic [3:0]  op;
    logic [27:0] e;
    op = ins[7:4];
    zero_flag = z;
    mem_ready = 1'b1;
    instr = ins;
    step(ev(0, 0, 0, 3'd0, 0, 0, 0, 0, 0), "fetch");
    m_ir = ins;
    instr = ~ins;
    step(ev(0, 0, 0, 3'd0, 0, 0, 0, 0, 0), "decode");
    case (op)
      4'h0: e = ev(1, 0, 0, 3'd0, 0, 0, 0, 0, 0);
      4'h1: e = ev(1, 0, 0, 3'd0, 1, 0, 0, 0, 0);
      4'h2: e = ev(1, 0, 0, 3'd1, 1, 0, 0, 0, 0);
      4'h3: e = ev(1, 0, 0, 3'd2, 1, 0, 0, 0, 0);
      4'h4: e = ev(1, 0, 0, 3'd3, 1, 0, 0, 0, 0);
      4'h5: e = ev(1, 0, 0, 3'd4, 1, 0, 0, 0, 0);
      4'h6: e = ev(1, 0, 0, 3'd5, 1, 0, 0, 0, 0);
      4'h7, 4'h8, 4'hF: e = ev(0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
      4'h9: e = ev(0, 1, 0, 3'd0, 0, 0, 0, 0, 0);
      4'hA: e = ev(0, 1, 1, 3'd0, 0, 0, 0, 0, 0);
      4'hB: e = z ? ev(0, 1, 0, 3'd0, 0, 0, 0, 0, 0) : ev(1, 0, 0, 3'd0, 0, 0, 0, 0, 0);
      default: e = ev(1, 0, 0, 3'd0, 0, 0, 0, 0, 1);
    endcase
    step(e, "exec");
    if (op == 4'h7 || op == 4'h8) begin
      for (int k = 0; k < WAIT_MAX; k++) begin
        mem_ready = (k == rdy_at);
        if (k == abort_at) begin
          CLB = 1'b1;
          model_reset();
          step(ev(0, 0, 0, 3'd0, 0, 0, 0, 0, 0), "mid_mem_reset");
          CLB = 1'b0;
          mem_ready = 1'b0;
          return;
        end
        if (k == rdy_at) begin
          step(ev(1, 0, 0, 3'd0, op == 4'h7, 1, op == 4'h8, 0, 0), "mem_done");
          mem_ready = 1'b0;
          return;
        end
        step(ev(0, 0, 0, 3'd0, 0, 1, op == 4'h8, 0, 0), "mem_wait");
      end
      m_merr = 1'b1;
    end
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      instr = 8'($urandom);
      mem_ready = i[0];
      zero_flag = i[1];
      step(ev(0, 0, 0, 3'd0, 0, 0, 0, 1, 0), "halted");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    CLB = 1'b1;
    instr = 8'h00;
    zero_flag = 1'b0;
    mem_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    run(8'h13, 0, -1, -1);
    run(8'h9A, 0, -1, -1);
    run(8'hA2, 0, -1, -1);
    run(8'hB5, 1, -1, -1);
    run(8'hB5, 0, -1, -1);
    run(8'h27, 1, -1, -1);
    run(8'h3E, 0, -1, -1);
    run(8'h41, 0, -1, -1);
    run(8'h5B, 0, -1, -1);
    run(8'h6D, 0, -1, -1);
    run(8'h00, 0, -1, -1);
    run(8'h76, 0, 3, -1);
    run(8'h86, 0, 0, -1);
    run(8'hC0, 0, -1, -1);
    run(8'hD5, 0, -1, -1);
    run(8'hE3, 0, -1, -1);
    run(8'h76, 0, WAIT_MAX - 1, -1);
    run(8'h86, 0, -1, -1);
    halt_cycles(4);

    do_reset();
    run(8'h13, 0, -1, -1);
    run(8'hF0, 0, -1, -1);
    halt_cycles(5);

    do_reset();
    run(8'h21, 0, -1, -1);
    run(8'h76, 0, -1, 2);
    run(8'h13, 0, -1, -1);

    do_reset();
    for (int i = 0; i < 257; i++)
      run({4'h0, 4'(i)}, 0, -1, -1);
    run(8'h9F, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Instruction fetch/decode/execute controller; drives the program counter strobes (IncPC, LoadPC, selPC, imm) and consumes the instruction word returned from instruction memory at the PC address.
- Multi-cycle FSM: holds the instruction register (IR), issues register-file, ALU and data-memory controls, and handles the data-memory ready handshake with a timeout.
- Sits between instruction memory and program counter, register file, ALU and data memory.

Parameters:
- WAIT_MAX, 15, maximum MEM-state cycles spent waiting for mem_ready before abort (1..255).

Ports:
- clk  input  1  rising-edge clock
- CLB  input  1  reset, asynchronous, active-high
- instr  input  8  instruction word from instruction memory at the current PC
- zero_flag  input  1  ALU zero flag, registered externally
- mem_ready  input  1  data-memory completion, sampled in MEM state
- IncPC  output  1  PC increment strobe
- LoadPC  output  1  PC load strobe
- selPC  output  1  PC load source: 1 = register (rs value), 0 = imm
- imm  output  4  IR[3:0], to PC and register-file immediate path
- rd  output  2  IR[3:2], destination/store-data register select
- rs  output  2  IR[1:0], source/address register select
- alu_op  output  3  0 pass-imm, 1 add, 2 sub, 3 and, 4 or, 5 pass-rs
- reg_we  output  1  register-file write enable
- mem_req  output  1  data-memory request, held until mem_ready or timeout
- mem_we  output  1  data-memory write (valid with mem_req)
- halted  output  1  FSM in HALT
- mem_err  output  1  sticky, set on mem_ready timeout
- illegal  output  1  one-cycle pulse on reserved opcode in EXEC
- instr_count  output  8  retired-instruction counter

Behaviour:
- Opcode = IR[7:4]: 0 NOP; 1 LDI (R0<-imm); 2 ADD, 3 SUB, 4 AND, 5 OR (rd<-rd op rs); 6 MOV (rd<-rs); 7 LD (rd<-mem[rs]); 8 ST (mem[rs]<-rd); 9 JMP imm; A JR rs; B BZ imm; C-E reserved; F HALT.
- States: FETCH -> DECODE -> EXEC -> {FETCH, MEM, HALT}; MEM -> {MEM, FETCH, HALT}; HALT is terminal until reset.
- FETCH: IR <= instr at the clock edge; all strobes 0.
- DECODE: one cycle of register read; all strobes 0.
- EXEC:
  - ALU ops, LDI, MOV: reg_we=1 and IncPC=1 with the matching alu_op (LDI/MOV rd forced to 0 for LDI).
  - NOP: IncPC=1.
  - Reserved opcodes: IncPC=1, illegal=1.
  - JMP: LoadPC=1, selPC=0.
  - JR: LoadPC=1, selPC=1.
  - BZ: zero_flag=1 gives LoadPC=1, selPC=0; otherwise IncPC=1.
  - LD/ST: go to MEM with no PC strobe.
  - HALT: go to HALT with no strobe.
- MEM:
  - mem_req=1 every cycle; mem_we=1 for ST.
  - On the cycle mem_ready=1: LD asserts reg_we=1; IncPC=1; next state FETCH.
  - Wait counter starts at 0 on entry. If the count reaches WAIT_MAX with no mem_ready: mem_req drops, mem_err sets, next state HALT, PC unchanged.
  - mem_ready outside MEM is ignored.
- Strobes are combinational from state, IR, zero_flag and mem_ready. IncPC and LoadPC are never 1 in the same cycle.
- instr_count increments on every cycle that has IncPC or LoadPC; wraps 255->0. HALT and timeout do not count.
- Latency: 3 cycles for non-memory instructions; LD/ST take 4 + wait cycles.
- Reset (CLB=1, any time, including mid-MEM):
  - state=FETCH, IR=0x00, wait counter=0, instr_count=0, mem_err=0.
  - All outputs 0; imm/rd/rs read 0.
  - The first FETCH happens on the first rising edge after CLB deasserts.

Test Plan:
- Reset then instr=0x13 (LDI 3): cycle 3 gives reg_we=1, alu_op=0, imm=3, IncPC=1; instr_count=1.
- JMP 0x9A then JR 0xA2: EXEC gives LoadPC=1, selPC=0, imm=0xA; next EXEC gives LoadPC=1, selPC=1, rs=2; IncPC=0 in both.
- BZ 0xB5 with zero_flag=1 gives LoadPC=1, imm=5. Repeat with zero_flag=0: IncPC=1, LoadPC=0.
- LD 0x76 with mem_ready delayed 3 cycles: mem_req=1 for 4 cycles, reg_we=1 and IncPC=1 only on the mem_ready cycle. ST 0x86: mem_we=1 throughout.
- ST with mem_ready never asserted, WAIT_MAX=15: mem_req drops after 15 MEM cycles, mem_err=1, halted=1, no PC strobe, instr_count unchanged.
- 0xC0 gives a one-cycle illegal pulse plus IncPC. 0xF0 gives halted=1 permanently. CLB pulse mid-MEM gives all outputs 0 immediately and instr_count=0.
